// File: rtl/dct_pkg.sv
// ============================================================================
//  Module   : dct_pkg
//  Purpose  : Shared constants and coefficient types for the 2-D 8x8 DCT
//             datapath (row pass, transpose buffer, column pass).
//  Contents : DCT_N  - block dimension (fixed at 8)
//             DCT_CW - coefficient width in bits
//             coef_t - one signed coefficient
//             row_t  - one row/column of DCT_N coefficients
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dct_pkg;

    localparam int DCT_N  = 8;
    localparam int DCT_CW = 12;

    typedef logic signed [DCT_CW-1:0] coef_t;
    typedef coef_t                    row_t [DCT_N];

endpackage : dct_pkg

`default_nettype wire

// File: rtl/dct_tp_bank.sv
// ============================================================================
//  Module   : dct_tp_bank
//  Purpose  : One NxN coefficient register bank. A whole row is written per
//             cycle; a whole column is read combinationally per cycle.
//  Ports    : clk     - clock
//             wr_en   - write wr_data into row wr_row on the rising edge
//             wr_row  - row address
//             wr_data - row lanes, lane k -> column k
//             rd_col  - column address
//             rd_data - column lanes, lane k = element at row k
//  Notes    : Contents are never reset; the control logic decides what is
//             valid through its full flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int DW = DCT_CW,
    parameter int N  = DCT_N
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [DW-1:0]        wr_data [N],
    input  logic [$clog2(N)-1:0] rd_col,
    output logic [DW-1:0]        rd_data [N]
);

    logic [DW-1:0] mem_q [N][N];
    logic [DW-1:0] mem_d [N][N];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int k = 0; k < N; k++) begin
                mem_d[wr_row][k] = wr_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Column read: lane k comes from row k.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            rd_data[k] = mem_q[k][rd_col];
        end
    end

endmodule : dct_tp_bank

`default_nettype wire

// File: rtl/dct_transpose_8x8.sv
// ============================================================================
//  Module   : dct_transpose_8x8
//  Purpose  : Ping-pong transpose buffer between the row-pass and column-pass
//             1-D DCTs. Accepts one row per cycle, emits the block one column
//             per cycle while the other bank is being filled.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_valid/in_ready   - row handshake
//             in0..in7            - row lanes, lane k = column k
//             out_valid/out_ready - column handshake (registered output)
//             out0..out7          - column lanes, lane k = row k
//             out_last            - column 7 marker (DCT_TP_LAST_EN only)
//  Config   : DCT_TP_LAST_EN - when defined, adds the out_last port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_transpose_8x8
    import dct_pkg::*;
#(
    parameter int DW = DCT_CW,
    parameter int N  = DCT_N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    input  logic [DW-1:0] in5,
    input  logic [DW-1:0] in6,
    input  logic [DW-1:0] in7,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out0,
    output logic [DW-1:0] out1,
    output logic [DW-1:0] out2,
    output logic [DW-1:0] out3,
    output logic [DW-1:0] out4,
    output logic [DW-1:0] out5,
    output logic [DW-1:0] out6,
    output logic [DW-1:0] out7
`ifdef DCT_TP_LAST_EN
    ,
    output logic          out_last
`endif
);

    localparam int            PW         = $clog2(N);
    localparam logic [PW-1:0] c_LAST_IDX = PW'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          wr_bank_q, wr_bank_d;
    logic [PW-1:0] wr_row_q,  wr_row_d;
    logic          rd_bank_q, rd_bank_d;
    logic [PW-1:0] rd_col_q,  rd_col_d;
    logic [1:0]    full_q,    full_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q [N];
    logic [DW-1:0] out_data_d [N];

    logic          w_accept;
    logic          w_load;
    logic [DW-1:0] w_in_row  [N];
    logic [DW-1:0] w_bank_rd [2][N];

    assign w_in_row[0] = in0;
    assign w_in_row[1] = in1;
    assign w_in_row[2] = in2;
    assign w_in_row[3] = in3;
    assign w_in_row[4] = in4;
    assign w_in_row[5] = in5;
    assign w_in_row[6] = in6;
    assign w_in_row[7] = in7;

    // Ready depends only on registered state (and rst), never on out_ready,
    // so a bank freed this cycle is offered to the writer next cycle.
    assign in_ready = !full_q[wr_bank_q] && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_load   = full_q[rd_bank_q] && (!out_valid_q || out_ready);

    // ------------------------------------------------------------------
    // Storage banks
    // ------------------------------------------------------------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tp_bank #(
            .DW (DW),
            .N  (N)
        ) u_bank (
            .clk     (clk),
            .wr_en   (w_accept && (wr_bank_q == 1'(b))),
            .wr_row  (wr_row_q),
            .wr_data (w_in_row),
            .rd_col  (rd_col_q),
            .rd_data (w_bank_rd[b])
        );
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_row_d    = wr_row_q;
        rd_bank_d   = rd_bank_q;
        rd_col_d    = rd_col_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (w_accept) begin
            wr_row_d = wr_row_q + 1'b1;
            if (wr_row_q == c_LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_row_d          = '0;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // Writer only touches a non-full bank and the reader only a full one,
        // so a set and a clear in the same cycle always hit different banks.
        if (w_load) begin
            out_data_d  = w_bank_rd[rd_bank_q];
            out_valid_d = 1'b1;
            rd_col_d    = rd_col_q + 1'b1;
            if (rd_col_q == c_LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_col_d          = '0;
                rd_bank_d         = !rd_bank_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_row_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_col_q    <= '0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                out_data_q[k] <= '0;
            end
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_row_q    <= wr_row_d;
            rd_bank_q   <= rd_bank_d;
            rd_col_q    <= rd_col_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out0      = out_data_q[0];
    assign out1      = out_data_q[1];
    assign out2      = out_data_q[2];
    assign out3      = out_data_q[3];
    assign out4      = out_data_q[4];
    assign out5      = out_data_q[5];
    assign out6      = out_data_q[6];
    assign out7      = out_data_q[7];

    // ------------------------------------------------------------------
    // Optional last-column marker, registered alongside the data
    // ------------------------------------------------------------------
`ifdef DCT_TP_LAST_EN
    logic out_last_q, out_last_d;

    always_comb begin
        out_last_d = out_last_q;
        if (w_load) begin
            out_last_d = (rd_col_q == c_LAST_IDX);
        end else if (out_ready) begin
            out_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_last_q <= 1'b0;
        end else begin
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`else
    // No last-column marker in this build.
`endif

endmodule : dct_transpose_8x8

`default_nettype wire
